// File: rtl/wdata_channel_router_if.sv
// rtl/wdata_channel_router_if.sv - signal bundle for the W channel router
// Purpose: groups the grant, master W, slave W and status signals of one
//          slave-port W router so they travel as a single port.
// Ports (signals):
//   grant_valid/grant_id/grant_ready      AW arbiter grant push
//   M0_wdata/M0_wstrb/M0_wvalid/M0_wready master 0 W channel
//   M1_wdata/M1_wstrb/M1_wvalid/M1_wready master 1 W channel
//   wlast_in                              last-beat flag from the wlast generator
//   S_wdata/S_wstrb/S_wvalid/S_wlast/S_wready slave W channel
//   wlast_gen_en/burst_beats/fifo_count   generator enable and status
// Modports: slave = router view, master = surrounding fabric / bench view.
interface wdata_channel_router_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int BEAT_CNT_W = 8
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic                  grant_valid;
  logic                  grant_id;
  logic                  grant_ready;

  logic [DATA_WIDTH-1:0] M0_wdata;
  logic [STRB_W-1:0]     M0_wstrb;
  logic                  M0_wvalid;
  logic                  M0_wready;

  logic [DATA_WIDTH-1:0] M1_wdata;
  logic [STRB_W-1:0]     M1_wstrb;
  logic                  M1_wvalid;
  logic                  M1_wready;

  logic                  wlast_in;

  logic [DATA_WIDTH-1:0] S_wdata;
  logic [STRB_W-1:0]     S_wstrb;
  logic                  S_wvalid;
  logic                  S_wlast;
  logic                  S_wready;

  logic                  wlast_gen_en;
  logic [BEAT_CNT_W-1:0] burst_beats;
  logic [CNT_W-1:0]      fifo_count;

  modport slave (
    input  grant_valid, grant_id,
    output grant_ready,
    input  M0_wdata, M0_wstrb, M0_wvalid,
    output M0_wready,
    input  M1_wdata, M1_wstrb, M1_wvalid,
    output M1_wready,
    input  wlast_in,
    output S_wdata, S_wstrb, S_wvalid, S_wlast,
    input  S_wready,
    output wlast_gen_en, burst_beats, fifo_count
  );

  modport master (
    output grant_valid, grant_id,
    input  grant_ready,
    output M0_wdata, M0_wstrb, M0_wvalid,
    input  M0_wready,
    output M1_wdata, M1_wstrb, M1_wvalid,
    input  M1_wready,
    output wlast_in,
    input  S_wdata, S_wstrb, S_wvalid, S_wlast,
    output S_wready,
    input  wlast_gen_en, burst_beats, fifo_count
  );
endinterface

// File: rtl/wdata_channel_router.sv
// rtl/wdata_channel_router.sv - W channel router for one slave port shared by two masters
// Purpose: AW grants are queued in order in a grant FIFO; the master whose grant
//          is at the FIFO head owns the slave W channel until its last-beat
//          handshake (wlast_in from the wlast generator), then the grant pops.
// Ports:
//   ACLK     clock
//   ARESETN  asynchronous active-low reset
//   bus      wdata_channel_router_if.slave (grant, M0/M1 W, slave W, status)
// Configuration macro: W_OUT_REG_EN - when defined, a 2-entry skid buffer
//   registers S_wdata/S_wstrb/S_wvalid/S_wlast (+1 cycle, full throughput) and
//   master wready becomes "buffer not full"; grant pop and burst_beats then
//   follow the master-side acceptance into the buffer.
module wdata_channel_router #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int BEAT_CNT_W = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  wdata_channel_router_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_ROUTE = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [BEAT_CNT_W-1:0] r_burst_beats;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head;
  logic                  w_route;

  logic                  w_sel_wvalid;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [STRB_W-1:0]     w_sel_wstrb;

  // w_acc_ready: whether the slave side can take a beat this cycle.
  // w_accept: a beat from the head master is taken this cycle.
  logic                  w_acc_ready;
  logic                  w_accept;

  logic                  w_m0_wready;
  logic                  w_m1_wready;
  logic                  w_wlast_gen_en;

  logic                  w_s_wvalid;
  logic                  w_s_wlast;
  logic [DATA_WIDTH-1:0] w_s_wdata;
  logic [STRB_W-1:0]     w_s_wstrb;

  // Grant FIFO status. No pass-through: a full FIFO refuses a grant even when
  // it pops in the same cycle.
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.grant_valid && !w_full;
  assign w_head  = r_fifo_mem[r_rd_ptr];
  assign w_route = (r_state == ST_ROUTE);

  assign w_sel_wvalid = w_head ? bus.M1_wvalid : bus.M0_wvalid;
  assign w_sel_wdata  = w_head ? bus.M1_wdata  : bus.M0_wdata;
  assign w_sel_wstrb  = w_head ? bus.M1_wstrb  : bus.M0_wstrb;

  assign w_accept    = w_route && w_sel_wvalid && w_acc_ready;
  assign w_pop       = w_accept && bus.wlast_in;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_mem[i] <= 1'b0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_ptr] <= bus.grant_id;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // IDLE waits one cycle after the FIFO turns non-empty (no bypass). ROUTE
  // leaves only when the last beat pops the final entry, so a grant pushed in
  // the same cycle keeps bursts back-to-back.
  always_comb begin
    w_state_nxt    = r_state;
    w_m0_wready    = 1'b0;
    w_m1_wready    = 1'b0;
    w_wlast_gen_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_ROUTE;
        end
      end
      ST_ROUTE: begin
        w_wlast_gen_en = 1'b1;
        w_m0_wready    = !w_head && w_acc_ready;
        w_m1_wready    = w_head && w_acc_ready;
        if (w_pop && (w_count_nxt == '0)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Beat counter: clear on the last beat wins over the increment; saturates.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_burst_beats <= '0;
    end else if (w_pop) begin
      r_burst_beats <= '0;
    end else if (w_accept && (r_burst_beats != '1)) begin
      r_burst_beats <= r_burst_beats + BEAT_CNT_W'(1);
    end
  end

`ifdef W_OUT_REG_EN
  logic [DATA_WIDTH-1:0] r_sb_data [2];
  logic [STRB_W-1:0]     r_sb_strb [2];
  logic                  r_sb_last [2];
  logic                  r_sb_wr;
  logic                  r_sb_rd;
  logic [1:0]            r_sb_count;
  logic                  w_sb_pop;

  // Master ready only looks at buffer occupancy, breaking the S_wready path.
  assign w_acc_ready = (r_sb_count != 2'd2);
  assign w_sb_pop    = (r_sb_count != 2'd0) && bus.S_wready;

  assign w_s_wvalid = (r_sb_count != 2'd0);
  assign w_s_wdata  = r_sb_data[r_sb_rd];
  assign w_s_wstrb  = r_sb_strb[r_sb_rd];
  assign w_s_wlast  = r_sb_last[r_sb_rd];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 2; i++) begin
        r_sb_data[i] <= '0;
        r_sb_strb[i] <= '0;
        r_sb_last[i] <= 1'b0;
      end
      r_sb_wr    <= 1'b0;
      r_sb_rd    <= 1'b0;
      r_sb_count <= 2'd0;
    end else begin
      if (w_accept) begin
        r_sb_data[r_sb_wr] <= w_sel_wdata;
        r_sb_strb[r_sb_wr] <= w_sel_wstrb;
        r_sb_last[r_sb_wr] <= bus.wlast_in;
        r_sb_wr            <= ~r_sb_wr;
      end
      if (w_sb_pop) begin
        r_sb_rd <= ~r_sb_rd;
      end
      r_sb_count <= r_sb_count + 2'(w_accept) - 2'(w_sb_pop);
    end
  end
`else
  // Zero-latency path: outputs are forced to 0 outside ROUTE.
  assign w_acc_ready = bus.S_wready;
  assign w_s_wvalid  = w_route && w_sel_wvalid;
  assign w_s_wdata   = w_route ? w_sel_wdata : '0;
  assign w_s_wstrb   = w_route ? w_sel_wstrb : '0;
  assign w_s_wlast   = w_route && bus.wlast_in;
`endif

  assign bus.grant_ready  = !w_full;
  assign bus.M0_wready    = w_m0_wready;
  assign bus.M1_wready    = w_m1_wready;
  assign bus.S_wdata      = w_s_wdata;
  assign bus.S_wstrb      = w_s_wstrb;
  assign bus.S_wvalid     = w_s_wvalid;
  assign bus.S_wlast      = w_s_wlast;
  assign bus.wlast_gen_en = w_wlast_gen_en;
  assign bus.burst_beats  = r_burst_beats;
  assign bus.fifo_count   = r_count;
endmodule

// File: tb/tb_wdata_channel_router.sv
// tb/tb_wdata_channel_router.sv - self-checking bench for wdata_channel_router
module tb_wdata_channel_router;
  localparam int DW = 32;
  localparam int FD = 4;
  localparam int BW = 8;
`ifdef W_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  wdata_channel_router_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BEAT_CNT_W(BW)) bus();

  wdata_channel_router #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .BEAT_CNT_W(BW)) dut (
    .ACLK   (ACLK),
    .ARESETN(ARESETN),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model state for the multi-cycle sequences
  typedef struct { logic id; int len; } grant_t;
  typedef struct { logic [31:0] d; logic [3:0] s; logic l; } beat_t;

  grant_t gq[$];   // grants still to be offered
  grant_t wq[$];   // grants accepted, in order, head = current owner
  beat_t  eq[$];   // expected slave-side beats
  int   m_idx [2];
  int   alloc [2];
  logic m_en [2];
  int   m_beat, cnt_m, bb_m;
  logic st_m;
  int   cyc = 0;
  logic rdy_toggle = 1'b0;
  int   low_from = 0, low_to = 0;
  int   hs_n, acc_n, first_hs, last_hs, first_acc, gaps, bb_max;
  logic prev_stall;
  logic [31:0] prev_d;
  logic ready_chk_pending, pp_pending;
  int   pp_cnt;

  function automatic logic [31:0] base(input logic id);
    return id ? 32'hB000_0000 : 32'hA000_0000;
  endfunction

  function automatic logic [3:0] strb(input logic id);
    return id ? 4'h5 : 4'hF;
  endfunction

  task automatic model_reset();
    gq.delete(); wq.delete(); eq.delete();
    for (int i = 0; i < 2; i++) begin m_idx[i] = 0; alloc[i] = 0; m_en[i] = 1'b0; end
    m_beat = 0; cnt_m = 0; bb_m = 0; st_m = 1'b0;
    prev_stall = 1'b0; prev_d = '0;
    ready_chk_pending = 1'b0; pp_pending = 1'b0; pp_cnt = 0;
  endtask

  task automatic clear_stats();
    hs_n = 0; acc_n = 0; first_hs = -1; last_hs = -1; first_acc = -1; gaps = 0; bb_max = 0;
  endtask

  task automatic drive_idle();
    bus.grant_valid = 1'b0; bus.grant_id = 1'b0;
    bus.M0_wvalid = 1'b0; bus.M0_wdata = '0; bus.M0_wstrb = '0;
    bus.M1_wvalid = 1'b0; bus.M1_wdata = '0; bus.M1_wstrb = '0;
    bus.S_wready = 1'b0; bus.wlast_in = 1'b0;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    drive_idle();
    model_reset();
    clear_stats();
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  task automatic check_idle(input string name);
    check(name,
          {bus.S_wvalid, bus.S_wlast, bus.M0_wready, bus.M1_wready, bus.wlast_gen_en,
           bus.grant_ready, bus.S_wstrb, bus.fifo_count, bus.burst_beats, bus.S_wdata},
          {5'b00000, 1'b1, 4'h0, 3'd0, 8'd0, 32'h0});
  endtask

  // One clock: drive after the edge, compare and update the model at negedge.
  task automatic step();
    logic acc0, acc1, acc, push, pop, last_in;
    int   cnt_before, nxt;
    grant_t g;
    beat_t b;
    bus.grant_valid = (gq.size() != 0);
    bus.grant_id    = (gq.size() != 0) ? gq[0].id : 1'b0;
    bus.M0_wvalid   = m_en[0];
    bus.M0_wdata    = base(1'b0) | 32'(m_idx[0]);
    bus.M0_wstrb    = strb(1'b0);
    bus.M1_wvalid   = m_en[1];
    bus.M1_wdata    = base(1'b1) | 32'(m_idx[1]);
    bus.M1_wstrb    = strb(1'b1);
    bus.S_wready    = rdy_toggle ? (cyc % 2 == 0) : !(cyc >= low_from && cyc < low_to);
    last_in         = (wq.size() != 0) && (m_beat == wq[0].len - 1);
    bus.wlast_in    = last_in;
    @(negedge ACLK);

    check("fifo_count", bus.fifo_count, cnt_m);
    check("grant_ready", bus.grant_ready, cnt_m < FD);
    check("wlast_gen_en", bus.wlast_gen_en, st_m);
    check("burst_beats", bus.burst_beats, bb_m);
    if (prev_stall) check("stall_data_stable", bus.S_wdata, prev_d);
    if (ready_chk_pending) check("ready_after_full_pop", bus.grant_ready, 1'b1);
    if (pp_pending) check("pushpop_count", bus.fifo_count, pp_cnt);
    ready_chk_pending = 1'b0;
    pp_pending = 1'b0;

    acc0 = bus.M0_wvalid && bus.M0_wready;
    acc1 = bus.M1_wvalid && bus.M1_wready;
    acc  = acc0 || acc1;
    if (acc) begin
      acc_n++;
      if (first_acc < 0) first_acc = cyc;
    end
    check("accept_owner", {acc1, acc0},
          !acc ? 2'b00 : (wq.size() == 0) ? 2'b11 : (wq[0].id ? 2'b10 : 2'b01));

    if (bus.S_wvalid && bus.S_wready) begin
      hs_n++;
      if (first_hs < 0) first_hs = cyc;
      else if (cyc != last_hs + 1) gaps++;
      last_hs = cyc;
      if (eq.size() == 0) begin
        check("unexpected_beat", 1'b1, 1'b0);
      end else begin
        b = eq.pop_front();
        check("s_beat", {bus.S_wdata, bus.S_wstrb, bus.S_wlast}, {b.d, b.s, b.l});
      end
    end
    prev_stall = bus.S_wvalid && !bus.S_wready;
    prev_d     = bus.S_wdata;
    if (int'(bus.burst_beats) > bb_max) bb_max = int'(bus.burst_beats);

    cnt_before = cnt_m;
    push = (gq.size() != 0) && (cnt_m < FD);
    pop  = 1'b0;
    if (acc && wq.size() != 0) begin
      if (acc0) m_idx[0]++; else m_idx[1]++;
      if (last_in) begin
        pop = 1'b1;
        void'(wq.pop_front());
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end
    if (pop) bb_m = 0;
    else if (acc && bb_m < 255) bb_m++;
    if (push) begin
      g = gq.pop_front();
      wq.push_back(g);
      for (int k = 0; k < g.len; k++) begin
        eq.push_back('{base(g.id) | 32'(alloc[g.id]), strb(g.id), k == g.len - 1});
        alloc[g.id]++;
      end
    end
    nxt  = cnt_m + int'(push) - int'(pop);
    st_m = !st_m ? (cnt_m != 0) : (nxt != 0);
    if (pop && cnt_before == FD) ready_chk_pending = 1'b1;
    if (push && pop) begin pp_pending = 1'b1; pp_cnt = cnt_before; end
    cnt_m = nxt;

    @(posedge ACLK);
    #1 cyc++;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((gq.size() != 0 || wq.size() != 0 || eq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", n < budget, 1'b1);
  endtask

`ifndef W_OUT_REG_EN
  typedef struct {
    logic gv, gid, m0v; logic [31:0] m0d; logic sr, wl;
    logic gr, sv; logic [31:0] sd; logic [3:0] ss; logic sl, m0r, m1r, en;
    logic [2:0] cnt; logic [7:0] bb;
  } vec_t;
  vec_t vt[7];
`endif

  initial begin
    int n;
    model_reset();
    clear_stats();
    do_reset();
    @(negedge ACLK);
    check_idle("reset_state");
    @(posedge ACLK);
    #1;

`ifndef W_OUT_REG_EN
    // Single burst, M0, 4 beats. M1 holds wvalid=1 with data B0 throughout.
    //        gv   gid  m0v  m0d           sr   wl    gr   sv   sd            ss    sl   m0r  m1r  en   cnt   bb
    vt[0] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0, 1'b1,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,3'd0,8'd0};
    vt[1] = '{1'b0,1'b0,1'b1,32'hA0,       1'b1,1'b0, 1'b1,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,3'd1,8'd0};
    vt[2] = '{1'b0,1'b0,1'b1,32'hA0,       1'b1,1'b0, 1'b1,1'b1,32'hA0,       4'hF,1'b0,1'b1,1'b0,1'b1,3'd1,8'd0};
    vt[3] = '{1'b0,1'b0,1'b1,32'hA1,       1'b1,1'b0, 1'b1,1'b1,32'hA1,       4'hF,1'b0,1'b1,1'b0,1'b1,3'd1,8'd1};
    vt[4] = '{1'b0,1'b0,1'b1,32'hA2,       1'b1,1'b0, 1'b1,1'b1,32'hA2,       4'hF,1'b0,1'b1,1'b0,1'b1,3'd1,8'd2};
    vt[5] = '{1'b0,1'b0,1'b1,32'hA3,       1'b1,1'b1, 1'b1,1'b1,32'hA3,       4'hF,1'b1,1'b1,1'b0,1'b1,3'd1,8'd3};
    vt[6] = '{1'b0,1'b0,1'b1,32'hA4,       1'b1,1'b0, 1'b1,1'b0,32'h0,        4'h0,1'b0,1'b0,1'b0,1'b0,3'd0,8'd0};
    for (int i = 0; i < 7; i++) begin
      bus.grant_valid = vt[i].gv;  bus.grant_id = vt[i].gid;
      bus.M0_wvalid = vt[i].m0v;   bus.M0_wdata = vt[i].m0d;  bus.M0_wstrb = 4'hF;
      bus.M1_wvalid = 1'b1;        bus.M1_wdata = 32'hB0;     bus.M1_wstrb = 4'h5;
      bus.S_wready = vt[i].sr;     bus.wlast_in = vt[i].wl;
      @(negedge ACLK);
      check($sformatf("single_burst_vec%0d", i),
            {bus.grant_ready, bus.S_wvalid, bus.S_wlast, bus.M0_wready, bus.M1_wready,
             bus.wlast_gen_en, bus.S_wstrb, bus.fifo_count, bus.burst_beats, bus.S_wdata},
            {vt[i].gr, vt[i].sv, vt[i].sl, vt[i].m0r, vt[i].m1r, vt[i].en,
             vt[i].ss, vt[i].cnt, vt[i].bb, vt[i].sd});
      @(posedge ACLK);
      #1;
    end
`endif

    // Ordering: grant 1 (16 beats) then grant 0 (4 beats), both masters valid.
    do_reset();
    m_en[0] = 1'b1; m_en[1] = 1'b1;
    gq.push_back('{1'b1, 16});
    gq.push_back('{1'b0, 4});
    run_until_done(200);
    check("order_beats", hs_n, 20);
    check("order_gaps", gaps, 0);
    check("order_latency", first_hs - first_acc, LAT);

    // Backpressure: S_wready toggles during an 8-beat burst.
    do_reset();
    m_en[0] = 1'b1; m_en[1] = 1'b1;
    rdy_toggle = 1'b1;
    gq.push_back('{1'b0, 8});
    run_until_done(200);
    rdy_toggle = 1'b0;
    check("bp_beats", hs_n, 8);
    check("bp_bb_max", bb_max, 7);
    check("bp_bb_final", bus.burst_beats, 8'd0);

    // S_wready low for two cycles in the middle of back-to-back bursts.
    do_reset();
    m_en[0] = 1'b1; m_en[1] = 1'b1;
    low_from = cyc + 5; low_to = cyc + 7;
    gq.push_back('{1'b0, 6});
    gq.push_back('{1'b1, 6});
    run_until_done(200);
    check("drop_beats", hs_n, 12);
    low_from = 0; low_to = 0;

    // FIFO full: four grants without W traffic, fifth held off.
    do_reset();
    gq.push_back('{1'b0, 2});
    gq.push_back('{1'b1, 1});
    gq.push_back('{1'b0, 1});
    gq.push_back('{1'b1, 1});
    gq.push_back('{1'b0, 1});
    repeat (8) step();
    check("full_grant_ready", bus.grant_ready, 1'b0);
    check("full_fifo_count", bus.fifo_count, 3'd4);
    check("full_fifth_held", gq.size(), 1);
    m_en[0] = 1'b1; m_en[1] = 1'b1;
    run_until_done(100);
    check("full_total_beats", hs_n, 6);

    // Reset in the middle of an 8-beat burst, then a clean M1 burst.
    do_reset();
    m_en[0] = 1'b1; m_en[1] = 1'b1;
    gq.push_back('{1'b0, 8});
    n = 0;
    while (bb_m != 3 && n < 30) begin step(); n++; end
    check("mid_burst_reached", bb_m, 3);
    #2 ARESETN = 1'b0;
    #1 check_idle("reset_mid_burst");
    model_reset();
    clear_stats();
    m_en[0] = 1'b1; m_en[1] = 1'b1;
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    gq.push_back('{1'b1, 4});
    run_until_done(100);
    check("post_reset_beats", hs_n, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
